// File: rtl/shift_rr_sched.sv
// +----------------------------------------------------------------------------+
// | shift_rr_sched: two-requester round-robin scheduler for a 4-bit serial     |
// | logical right shifter.                                Revision: 1.0        |
// +----------------------------------------------------------------------------+
`default_nettype none

module shift_rr_sched (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  output logic       req1_ready,
  output logic       res_valid,
  output logic [3:0] res_data,
  output logic       res_id,
  input  logic       res_ready,
  output logic       busy
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_SHIFT = 2'd1;
  localparam logic [1:0] c_DONE  = 2'd2;

  logic [1:0] r_state;
  logic       r_rr;
  logic [2:0] r_cnt;
  logic [3:0] r_data;
  logic       r_id;

  logic       w_grant;
  logic       w_gnt_id;
  logic [3:0] w_gnt_a;
  logic [3:0] w_gnt_b;

  // Both pending: the round-robin pointer decides; otherwise the lone requester wins.
  always_comb begin
    w_grant  = (r_state == c_IDLE) && (req0_valid || req1_valid);
    w_gnt_id = (req0_valid && req1_valid) ? r_rr : req1_valid;
    w_gnt_a  = w_gnt_id ? req1_a : req0_a;
    w_gnt_b  = w_gnt_id ? req1_b : req0_b;
  end

  assign req0_ready = w_grant && !w_gnt_id;
  assign req1_ready = w_grant &&  w_gnt_id;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_IDLE;
      r_rr    <= 1'b0;
      r_cnt   <= 3'd0;
      r_data  <= 4'd0;
      r_id    <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_grant) begin
            r_data  <= w_gnt_a;
            r_id    <= w_gnt_id;
            // Four shifts already clear a 4-bit operand, so larger amounts saturate.
            r_cnt   <= (w_gnt_b >= 4'd4) ? 3'd4 : w_gnt_b[2:0];
            r_state <= (w_gnt_b == 4'd0) ? c_DONE : c_SHIFT;
          end
        end
        c_SHIFT: begin
          r_data <= {1'b0, r_data[3:1]};
          r_cnt  <= r_cnt - 3'd1;
          if (r_cnt == 3'd1) begin
            r_state <= c_DONE;
          end
        end
        c_DONE: begin
          if (res_ready) begin
            r_state <= c_IDLE;
            r_rr    <= ~r_id;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign res_valid = (r_state == c_DONE);
  assign res_data  = r_data;
  assign res_id    = r_id;
  assign busy      = (r_state != c_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_shift_rr_sched.sv
// +----------------------------------------------------------------------------+
// | tb_shift_rr_sched: self-checking bench for shift_rr_sched.  Revision: 1.0  |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_shift_rr_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic       req0_ready, req1_ready;
  logic       res_valid;
  logic [3:0] res_data;
  logic       res_id;
  logic       res_ready;
  logic       busy;

  shift_rr_sched dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_id     (res_id),
    .res_ready  (res_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v0;
    logic [3:0] a0;
    logic [3:0] b0;
    logic       v1;
    logic [3:0] a1;
    logic [3:0] b1;
    logic [1:0] exp_rdy;   // {req1_ready, req0_ready}
    int         exp_lat;
    logic [3:0] exp_data;
    logic       exp_id;
  } vec_t;

  typedef struct {
    logic       id;
    logic [3:0] data;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[8];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_exp(input logic id, input logic [3:0] data);
    exp_t e;
    e.id   = id;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic wait_result(output int n);
    n = 0;
    while (res_valid !== 1'b1 && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic check_result(input string nm);
    exp_t e;
    if (sb.size() == 0) begin
      chk({nm, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({nm, "_valid"}, res_valid, 1'b1);
      chk({nm, "_data"}, res_data, e.data);
      chk({nm, "_id"}, res_id, e.id);
    end
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_a = 4'($urandom);
    req0_b = 4'($urandom);
    req1_a = 4'($urandom);
    req1_b = 4'($urandom);
  endtask

  initial begin
    int n;
    int seen;
    int results;
    int grants;

    // Expected values worked out by hand, tracking rr from 0 after reset.
    vecs[0] = '{1'b1, 4'b1011, 4'd2, 1'b0, 4'h0, 4'd0, 2'b01, 2, 4'b0010, 1'b0};
    vecs[1] = '{1'b0, 4'h0,    4'd0, 1'b1, 4'hA, 4'd0, 2'b10, 0, 4'hA,    1'b1};
    vecs[2] = '{1'b1, 4'hF,    4'd9, 1'b0, 4'h0, 4'd0, 2'b01, 4, 4'h0,    1'b0};
    vecs[3] = '{1'b1, 4'hC,    4'd1, 1'b1, 4'h9, 4'd3, 2'b10, 3, 4'h1,    1'b1};
    vecs[4] = '{1'b1, 4'hC,    4'd1, 1'b1, 4'h9, 4'd3, 2'b01, 1, 4'h6,    1'b0};
    vecs[5] = '{1'b0, 4'h0,    4'd0, 1'b1, 4'hF, 4'd4, 2'b10, 4, 4'h0,    1'b1};
    vecs[6] = '{1'b1, 4'h8,    4'd3, 1'b0, 4'h0, 4'd0, 2'b01, 3, 4'h1,    1'b0};
    vecs[7] = '{1'b1, 4'h7,    4'd0, 1'b1, 4'h6, 4'd1, 2'b10, 1, 4'h3,    1'b1};

    rst = 1'b1;
    res_ready = 1'b1;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_res_data", res_data, 4'h0);
    chk("rst_res_id", res_id, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", {req1_ready, req0_ready}, 2'b00);

    foreach (vecs[i]) begin
      @(negedge clk);
      req0_valid = vecs[i].v0; req0_a = vecs[i].a0; req0_b = vecs[i].b0;
      req1_valid = vecs[i].v1; req1_a = vecs[i].a1; req1_b = vecs[i].b1;
      #1;
      chk($sformatf("v%0d_grant", i), {req1_ready, req0_ready}, vecs[i].exp_rdy);
      push_exp(vecs[i].exp_id, vecs[i].exp_data);
      @(posedge clk); #1;
      idle_inputs();
      chk($sformatf("v%0d_busy", i), busy, 1'b1);
      wait_result(n);
      chk($sformatf("v%0d_latency", i), n, vecs[i].exp_lat);
      check_result($sformatf("v%0d", i));
      @(posedge clk); #1;
      chk($sformatf("v%0d_idle", i), busy, 1'b0);
    end

    // Backpressure: the result must freeze in DONE and block new grants.
    res_ready = 1'b0;
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 4'hD; req0_b = 4'd1;
    #1 chk("bp_grant", {req1_ready, req0_ready}, 2'b01);
    push_exp(1'b0, 4'h6);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b1;
    wait_result(n);
    chk("bp_latency", n, 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      req0_valid = 1'b1; req1_valid = k[0];
      req0_a = 4'($urandom); req1_b = 4'($urandom);
      #1;
      chk("bp_no_ready", {req1_ready, req0_ready}, 2'b00);
      chk("bp_stable_valid", res_valid, 1'b1);
      chk("bp_stable_data", res_data, 4'h6);
      chk("bp_stable_id", res_id, 1'b0);
    end
    idle_inputs();
    check_result("bp");
    @(negedge clk) res_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_done_idle", busy, 1'b0);

    // Mid-operation reset: rr is 1 here, so a both-valid grant to 0 afterwards shows rr cleared.
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 4'hF; req0_b = 4'd3;
    #1 chk("mr_grant", {req1_ready, req0_ready}, 2'b01);
    @(posedge clk); #1;
    idle_inputs();
    chk("mr_busy", busy, 1'b1);
    @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mr_busy_after", busy, 1'b0);
    chk("mr_res_valid", res_valid, 1'b0);
    chk("mr_res_data", res_data, 4'h0);
    chk("mr_res_id", res_id, 1'b0);
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (res_valid === 1'b1) seen++;
    end
    chk("mr_no_delivery", seen, 0);
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 4'h5; req0_b = 4'd0;
    req1_valid = 1'b1; req1_a = 4'h3; req1_b = 4'd2;
    #1 chk("mr_rr_cleared", {req1_ready, req0_ready}, 2'b01);
    push_exp(1'b0, 4'h5);
    @(posedge clk); #1;
    idle_inputs();
    wait_result(n);
    chk("mr_latency", n, 0);
    check_result("mr");
    @(posedge clk); #1;

    // Contention from reset: both valid throughout, grants must alternate 0,1,0,1.
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    req0_valid = 1'b1; req0_a = 4'h6; req0_b = 4'd1;
    req1_valid = 1'b1; req1_a = 4'h9; req1_b = 4'd1;
    results = 0;
    grants = 0;
    for (int c = 0; c < 40 && results < 4; c++) begin
      @(negedge clk); #1;
      if ((req0_ready || req1_ready) && grants < 4) begin
        chk($sformatf("ct_grant%0d", grants), {req1_ready, req0_ready},
            (grants % 2 == 0) ? 2'b01 : 2'b10);
        push_exp(grants % 2 == 1, (grants % 2 == 1) ? 4'h4 : 4'h3);
        grants++;
      end
      @(posedge clk); #1;
      if (res_valid === 1'b1) begin
        check_result($sformatf("ct_res%0d", results));
        results++;
      end
    end
    chk("ct_result_count", results, 4);
    idle_inputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
